// File: rtl/gf180mcu_fd_sc_mcu9t5v0_antdrv_pkg.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0_antdrv_pkg
// Shared types and constants for the antenna-net stimulus driver.
//   mode_e             : waveform selection (static low/high, square, PRBS16)
//   state_e            : sequencer states
//   LFSR_TAP_MASK      : feedback taps of the right-shifting Fibonacci LFSR
//   LFSR_DEFAULT_SEED  : reset seed used when the top is not overridden
// -----------------------------------------------------------------------------
package gf180mcu_fd_sc_mcu9t5v0_antdrv_pkg;

    typedef enum logic [1:0] {
        MODE_LOW    = 2'd0,
        MODE_HIGH   = 2'd1,
        MODE_TOGGLE = 2'd2,
        MODE_PRBS   = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Polynomial x^16+x^14+x^13+x^11+1. The register shifts right, so
    // polynomial term k maps to bit (16-k): taps 16,14,13,11 -> bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAP_MASK     = 16'h002D;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic lfsr_feedback(input logic [15:0] state);
        return ^(state & LFSR_TAP_MASK);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__antdrv_lfsr16.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__antdrv_lfsr16
// 16-bit Fibonacci PRBS generator, shifts right once per enabled cycle.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, loads SEED
//   en_i    : shift enable
//   sout_o  : serial output; the bit 0 value the register will hold after
//             the next enabled shift, so a downstream register sampling it
//             together with en_i sees "bit 0 after the shift"
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__antdrv_lfsr16
    import gf180mcu_fd_sc_mcu9t5v0_antdrv_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sout_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {lfsr_feedback(lfsr_q), lfsr_q[15:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // A right shift moves bit 1 into bit 0.
    assign sout_o = lfsr_q[1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__antenna_drv_seq.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__antenna_drv_seq
// Drives a programmed waveform onto an antenna-protected net for a programmed
// number of cycles and reports the number of edges driven.
//
// state | meaning
// IDLE  | Z holds, waiting for START
// RUN   | Z updated every cycle, remaining-cycle counter counting down
//
// Ports:
//   clk_i      : clock, all state updates on rising edge
//   rst_i      : synchronous active-high reset
//   start_i    : start request, sampled only in IDLE
//   mode_i     : 0 low, 1 high, 2 square, 3 PRBS16 (captured on START)
//   ncyc_i     : RUN cycle count (captured on START)
//   half_i     : square half-period minus 1 (captured on START)
//   z_o        : driven net value
//   busy_o     : high in RUN
//   done_o     : one-cycle pulse when RUN ends (or START with ncyc_i == 0)
//   toggles_o  : saturating count of Z transitions in the current/last run
// Optional (macro GF180MCU_FD_SC_MCU9T5V0_READBACK_CHECK_EN):
//   zrb_i      : net readback, compared against Z delayed by one cycle
//   mismatch_o : saturating count of RUN cycles where the readback differed
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__antenna_drv_seq
    import gf180mcu_fd_sc_mcu9t5v0_antdrv_pkg::*;
#(
    parameter int          CW        = 16,
    parameter int          HPW       = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [1:0]     mode_i,
    input  logic [CW-1:0]  ncyc_i,
    input  logic [HPW-1:0] half_i,
`ifdef GF180MCU_FD_SC_MCU9T5V0_READBACK_CHECK_EN
    input  logic           zrb_i,
    output logic [CW-1:0]  mismatch_o,
`endif
    output logic           z_o,
    output logic           busy_o,
    output logic           done_o,
    output logic [CW-1:0]  toggles_o
);

    state_e         state_q, state_d;
    mode_e          mode_q, mode_d;
    logic [HPW-1:0] half_q, half_d;
    logic [HPW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0]  rem_q, rem_d;
    logic [CW-1:0]  tog_q, tog_d;
    logic           z_q, z_d;
    logic           done_q, done_d;

    logic           start_acc;
    logic           advance;
    logic           lfsr_en;
    logic           lfsr_bit;
    mode_e          run_mode;
    logic [HPW-1:0] run_half;
    logic [HPW-1:0] run_hcnt;
    logic [CW-1:0]  tog_base;

    // The first Z update lands on the same edge that enters RUN, so while
    // IDLE the live inputs stand in for the not-yet-captured settings.
    assign run_mode = (state_q == IDLE) ? mode_e'(mode_i) : mode_q;
    assign run_half = (state_q == IDLE) ? half_i : half_q;
    assign run_hcnt = (state_q == IDLE) ? '0 : hcnt_q;

    assign start_acc = (state_q == IDLE) && start_i;
    // One Z update per BUSY cycle: on the START edge and on every RUN edge
    // except the one that returns to IDLE.
    assign advance   = (start_acc && (ncyc_i != '0)) ||
                       ((state_q == RUN) && (rem_q != CW'(1)));
    assign lfsr_en   = advance && (run_mode == MODE_PRBS);

    gf180mcu_fd_sc_mcu9t5v0__antdrv_lfsr16 #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (lfsr_en),
        .sout_o (lfsr_bit)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        half_d  = half_q;
        hcnt_d  = hcnt_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mode_d = mode_e'(mode_i);
                    half_d = half_i;
                    hcnt_d = '0;
                    rem_d  = ncyc_i;
                    if (ncyc_i != '0) begin
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                rem_d = rem_q - CW'(1);
                if (rem_q == CW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        z_d = z_q;
        if (advance) begin
            case (run_mode)
                MODE_LOW:  z_d = 1'b0;
                MODE_HIGH: z_d = 1'b1;
                MODE_TOGGLE: begin
                    // Invert at the start of each half-period window.
                    if (run_hcnt == '0) begin
                        z_d = ~z_q;
                    end
                    hcnt_d = (run_hcnt == run_half) ? '0 : run_hcnt + HPW'(1);
                end
                MODE_PRBS: z_d = lfsr_bit;
                default:   z_d = z_q;
            endcase
        end

        tog_base = start_acc ? '0 : tog_q;
        tog_d    = tog_base;
        if ((z_d != z_q) && (tog_base != '1)) begin
            tog_d = tog_base + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mode_q  <= MODE_LOW;
            half_q  <= '0;
            hcnt_q  <= '0;
            rem_q   <= '0;
            tog_q   <= '0;
            z_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            half_q  <= half_d;
            hcnt_q  <= hcnt_d;
            rem_q   <= rem_d;
            tog_q   <= tog_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    assign z_o       = z_q;
    assign busy_o    = (state_q == RUN);
    assign done_o    = done_q;
    assign toggles_o = tog_q;

`ifdef GF180MCU_FD_SC_MCU9T5V0_READBACK_CHECK_EN
    logic          z_dly_q;
    logic [CW-1:0] mm_q, mm_d;

    always_comb begin
        mm_d = start_acc ? '0 : mm_q;
        if ((state_q == RUN) && (zrb_i != z_dly_q) && (mm_q != '1)) begin
            mm_d = mm_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            z_dly_q <= 1'b0;
            mm_q    <= '0;
        end else begin
            z_dly_q <= z_q;
            mm_q    <= mm_d;
        end
    end

    assign mismatch_o = mm_q;
`endif

endmodule
